seq_signed_divider: RTL and testbench
=====================================

Name: seq_signed_divider

Overview:
- Iterative signed integer divider, WIDTH-bit dividend / WIDTH-bit divisor -> WIDTH-bit quotient + remainder.
- Inverse datapath companion to the combinational Booth multiplier.
- Restoring algorithm on magnitudes, one quotient bit per clock, sign correction at the end.
- Sits beside the multiplier in the arithmetic unit; start/busy/done handshake to the controlling sequencer.

Parameters:
WIDTH, 8, operand/result width in bits (two's complement); must be >= 2

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
dividend  input  WIDTH  signed dividend, captured on accepting edge
divisor  input  WIDTH  signed divisor, captured on accepting edge
busy  output  1  high while a division is in progress
done  output  1  single-cycle pulse, results valid
quotient  output  WIDTH  signed quotient, held until next done
remainder  output  WIDTH  signed remainder, held until next done
dbz  output  1  divide-by-zero flag for the last result
ovf  output  1  overflow flag for the last result (most-negative / -1)

Behaviour:
- Clock and reset are fixed: single clock clk; reset rst is asynchronous and active-high.
- Reset, async, any state: state=IDLE; busy=0, done=0, quotient=0, remainder=0, dbz=0, ovf=0; internal counter, remainder and magnitude registers cleared.
- States:
  - IDLE -> ITER on start=1.
  - ITER -> FIX after WIDTH iterations.
  - FIX -> IDLE.
- Accept (edge k, IDLE, start=1):
  - Capture sign flags; capture |dividend| and |divisor| as WIDTH-bit unsigned (most-negative maps to 2^(WIDTH-1)).
  - Partial remainder (WIDTH+1 bits) = 0; count = WIDTH-1; busy=1.
- ITER, edges k+1..k+WIDTH:
  - trial = {prem[WIDTH-1:0], qreg[MSB]} - {0, |divisor|}.
  - If trial is non-negative: prem=trial, shift 1 into qreg LSB.
  - Otherwise: prem=shifted value, shift 0 in.
  - count decrements; leave ITER when count==0.
- FIX, edge k+WIDTH+1:
  - quotient = qreg, negated if the signs differ.
  - remainder = prem, negated if the dividend is negative.
  - Register both; done=1 for exactly one cycle; busy=0 on the same edge.
- Latency: done high during the cycle after edge k+WIDTH+1 (10 edges after accept for WIDTH=8). Back-to-back: start may be accepted on the edge where done rises? No, done rises on the exit edge into IDLE, so the earliest new accept is the next edge.
- Rounding: truncation toward zero; the remainder takes the dividend's sign; |remainder| < |divisor|.
- Divide by zero (divisor==0):
  - Full latency still applies.
  - quotient = all ones, remainder = dividend, dbz=1, ovf=0.
- Overflow (dividend = -2^(WIDTH-1), divisor = -1):
  - quotient = -2^(WIDTH-1) (wraps), remainder = 0, ovf=1.
- start while busy: ignored, no queuing. Operand changes after accept do not affect the result.
- dbz/ovf update only at done and hold with the results.
- Reset mid-operation: immediate abort to reset values; no done pulse.

Optional Feature:
- Macro: DIV_EARLY_EXIT_EN.
- Defined:
  - Divisor==0, or the overflow case, is detected at accept.
  - FSM goes IDLE -> FIX directly, so done is high the cycle after edge k+1.
  - Result values and flags are identical to the full-latency case.
- Undefined: every operation takes the full WIDTH+2 edges, giving constant latency.

Decomposition:
- Package div_pkg:
  - State enum {IDLE, ITER, FIX}.
  - Default WIDTH constant.
  - Helper function for two's-complement magnitude/negate.
- Sub-module div_step (combinational): one restoring iteration.
  - Inputs: prem, next dividend bit, divisor magnitude.
  - Outputs: next prem, quotient bit.
  - Built on a subtract-with-borrow adder chain, analogous to the multiplier's per-step stage.
  - Instantiated once and reused each cycle.

Test Plan:
- 100 / 7 -> quotient=14 (0x0E), remainder=2, dbz=0, ovf=0; done exactly 10 edges after accept, busy high throughout.
- -100 / 7 -> quotient=0xF2 (-14), remainder=0xFE (-2); 100 / -7 -> quotient=0xF2, remainder=0x02; -100 / -7 -> quotient=0x0E, remainder=0xFE.
- -128 / -1 -> quotient=0x80, remainder=0, ovf=1; -128 / 1 -> quotient=0x80, ovf=0; 127 / -128 -> quotient=0, remainder=127.
- 5 / 0 -> quotient=0xFF, remainder=0x05, dbz=1. Latency is 10 edges without DIV_EARLY_EXIT_EN and 2 edges with it.
- Accept 100/7, pulse start with 50/5 at edge k+3 -> ignored; single done with 14/2; no second done.
- Assert rst at edge k+4 mid-ITER (asynchronously, between edges) -> all outputs 0 immediately, no done. After release, 9/3 -> quotient=3, remainder=0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: FSM states,
// default operand width and a two's-complement conditional-negate helper.
package div_pkg;

  // Default operand/result width.
  localparam int DIV_WIDTH = 8;

  // Widest operand the helper below can handle; callers zero-extend into it.
  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX
  } div_state_e;

  // Negates the value when 'negate' is set. Callers pass a zero-extended
  // WIDTH-bit value and keep the low WIDTH bits. The low bits of a wide
  // negate equal a WIDTH-bit negate, so most-negative stays 2^(WIDTH-1).
  function automatic logic [MAX_W-1:0] cond_negate(input logic [MAX_W-1:0] value,
                                                   input logic negate);
    return negate ? (~value + MAX_W'(1)) : value;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor magnitude through a
// ripple borrow chain, and keep or restore depending on the final borrow.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] prem,
  input  logic             din,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] prem_next,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic [WIDTH+1:0] borrow;

  assign shifted   = {prem, din};
  assign borrow[0] = 1'b0;

  // Full-subtractor cells for the bits where the divisor has a digit.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sub
      assign diff[gi]     = shifted[gi] ^ dvs[gi] ^ borrow[gi];
      assign borrow[gi+1] = (~shifted[gi] & dvs[gi]) |
                            (~(shifted[gi] ^ dvs[gi]) & borrow[gi]);
    end
  endgenerate

  // Top cell subtracts the zero extension bit of the divisor. Its difference
  // bit is never needed: when the trial succeeds the result is below the
  // divisor, so it always fits in WIDTH bits.
  assign borrow[WIDTH+1] = ~shifted[WIDTH] & borrow[WIDTH];

  assign q_bit     = ~borrow[WIDTH+1];
  assign prem_next = q_bit ? diff : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_signed_divider.sv
// Iterative signed divider: restoring division on magnitudes, one quotient
// bit per clock, with sign correction in a final FIX cycle.
// Define DIV_EARLY_EXIT_EN to skip the iterations for divide-by-zero and
// most-negative / -1; the results stay the same, only the latency changes.
module seq_signed_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dbz,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state_reg, state_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] prem_reg, prem_next;
  logic [WIDTH-1:0] qreg_reg, qreg_next;
  logic [WIDTH-1:0] dvs_reg, dvs_next;
  logic [WIDTH-1:0] dvd_reg, dvd_next;
  logic             neg_q_reg, neg_q_next;
  logic             neg_r_reg, neg_r_next;
  logic             dbz_pend_reg, dbz_pend_next;
  logic             ovf_pend_reg, ovf_pend_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic [WIDTH-1:0] quot_reg, quot_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic             dbz_reg, dbz_next;
  logic             ovf_reg, ovf_next;

  logic [WIDTH-1:0] step_prem;
  logic             step_q;

  // The dividend magnitude sits in qreg and is consumed MSB-first while
  // quotient bits shift in at the LSB.
  div_step #(.WIDTH(WIDTH)) u_step (
    .prem      (prem_reg),
    .din       (qreg_reg[WIDTH-1]),
    .dvs       (dvs_reg),
    .prem_next (step_prem),
    .q_bit     (step_q)
  );

  // Next-state and datapath/output updates for the IDLE/ITER/FIX sequence.
  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    prem_next     = prem_reg;
    qreg_next     = qreg_reg;
    dvs_next      = dvs_reg;
    dvd_next      = dvd_reg;
    neg_q_next    = neg_q_reg;
    neg_r_next    = neg_r_reg;
    dbz_pend_next = dbz_pend_reg;
    ovf_pend_next = ovf_pend_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    quot_next     = quot_reg;
    rem_next      = rem_reg;
    dbz_next      = dbz_reg;
    ovf_next      = ovf_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          neg_q_next    = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          neg_r_next    = dividend[WIDTH-1];
          qreg_next     = WIDTH'(cond_negate(MAX_W'(dividend), dividend[WIDTH-1]));
          dvs_next      = WIDTH'(cond_negate(MAX_W'(divisor), divisor[WIDTH-1]));
          dvd_next      = dividend;
          prem_next     = '0;
          count_next    = CW'(WIDTH - 1);
          dbz_pend_next = (divisor == '0);
          ovf_pend_next = (dividend == MOST_NEG) && (divisor == '1);
          busy_next     = 1'b1;
          state_next    = ITER;
`ifdef DIV_EARLY_EXIT_EN
          if ((divisor == '0) || ((dividend == MOST_NEG) && (divisor == '1))) begin
            state_next = FIX;
          end
`endif
        end
      end
      ITER: begin
        prem_next = step_prem;
        qreg_next = {qreg_reg[WIDTH-2:0], step_q};
        if (count_reg == '0) begin
          state_next = FIX;
        end else begin
          count_next = count_reg - CW'(1);
        end
      end
      FIX: begin
        // The overflow case needs no override: |q| = 2^(WIDTH-1) with equal
        // signs already yields the wrapped most-negative quotient and a zero
        // remainder, whether or not the iterations ran.
        if (dbz_pend_reg) begin
          quot_next = '1;
          rem_next  = dvd_reg;
        end else begin
          quot_next = WIDTH'(cond_negate(MAX_W'(qreg_reg), neg_q_reg));
          rem_next  = WIDTH'(cond_negate(MAX_W'(prem_reg), neg_r_reg));
        end
        dbz_next   = dbz_pend_reg;
        ovf_next   = ovf_pend_reg;
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      prem_reg     <= '0;
      qreg_reg     <= '0;
      dvs_reg      <= '0;
      dvd_reg      <= '0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      dbz_pend_reg <= 1'b0;
      ovf_pend_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      quot_reg     <= '0;
      rem_reg      <= '0;
      dbz_reg      <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      prem_reg     <= prem_next;
      qreg_reg     <= qreg_next;
      dvs_reg      <= dvs_next;
      dvd_reg      <= dvd_next;
      neg_q_reg    <= neg_q_next;
      neg_r_reg    <= neg_r_next;
      dbz_pend_reg <= dbz_pend_next;
      ovf_pend_reg <= ovf_pend_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      quot_reg     <= quot_next;
      rem_reg      <= rem_next;
      dbz_reg      <= dbz_next;
      ovf_reg      <= ovf_next;
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign quotient  = quot_reg;
  assign remainder = rem_reg;
  assign dbz       = dbz_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed plus short random bench for seq_signed_divider (WIDTH=8).
// Expected results are queued when an operation is started and popped when
// done pulses. Honours DIV_EARLY_EXIT_EN for the expected latency.
module tb_seq_signed_divider;

  localparam int W = 8;
`ifdef DIV_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, dbz, ovf;
  logic [W-1:0] quotient, remainder;

  int   total = 0;
  int   bad = 0;
  exp_t scoreboard[$];

  seq_signed_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   sa, sd;
    sa = int'($signed(a));
    sd = int'($signed(b));
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    if (sd == 0) begin
      e.q = '1; e.r = a; e.dbz = 1'b1;
    end else if (sa == -128 && sd == -1) begin
      e.q = 8'h80; e.r = '0; e.ovf = 1'b1;
    end else begin
      e.q = W'(sa / sd);
      e.r = W'(sa % sd);
    end
    return e;
  endfunction

  task automatic expect_res(input logic [W-1:0] q, input logic [W-1:0] r,
                            input logic d, input logic o);
    exp_t e;
    e.q = q; e.r = r; e.dbz = d; e.ovf = o;
    scoreboard.push_back(e);
  endtask

  // Run one operation; 'inject' > 0 pulses a stray start (50/5) sampled on
  // that edge number, counting the accept edge as 1.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int inject);
    int   lat;
    int   lat_exp;
    bit   busy_ok;
    int   extra;
    exp_t e;
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    while (!done && lat < 40) begin
      if (!busy) busy_ok = 1'b0;
      if (inject != 0 && lat == inject - 1) begin
        start = 1'b1; dividend = 8'd50; divisor = 8'd5;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    e = scoreboard.pop_front();
    lat_exp = (EARLY && (e.dbz || e.ovf)) ? 2 : W + 2;
    check({tag, ".done_seen"}, 32'(done), 32'd1);
    check({tag, ".latency"}, 32'(lat), 32'(lat_exp));
    check({tag, ".busy_during"}, 32'(busy_ok), 32'd1);
    check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
    check({tag, ".quotient"}, 32'(quotient), 32'(e.q));
    check({tag, ".remainder"}, 32'(remainder), 32'(e.r));
    check({tag, ".dbz"}, 32'(dbz), 32'(e.dbz));
    check({tag, ".ovf"}, 32'(ovf), 32'(e.ovf));
    $display("op %s: %0d / %0d -> q=%02h r=%02h dbz=%0b ovf=%0b latency=%0d",
             tag, $signed(a), $signed(b), quotient, remainder, dbz, ovf, lat);
    @(posedge clk);
    #1;
    check({tag, ".done_one_cycle"}, 32'(done), 32'd0);
    check({tag, ".quotient_held"}, 32'(quotient), 32'(e.q));
    if (inject != 0) begin
      extra = 0;
      repeat (14) begin
        @(posedge clk);
        #1;
        if (done) extra++;
      end
      check({tag, ".no_second_done"}, 32'(extra), 32'd0);
      check({tag, ".idle_after"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int           seen;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.quotient", 32'(quotient), 32'd0);
    check("reset.remainder", 32'(remainder), 32'd0);
    check("reset.dbz", 32'(dbz), 32'd0);
    check("reset.ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Sign combinations and boundaries.
    expect_res(8'h0E, 8'h02, 1'b0, 1'b0); run_op("p100_p7", 8'd100, 8'd7, 0);
    expect_res(8'hF2, 8'hFE, 1'b0, 1'b0); run_op("n100_p7", 8'h9C, 8'd7, 0);
    expect_res(8'hF2, 8'h02, 1'b0, 1'b0); run_op("p100_n7", 8'd100, 8'hF9, 0);
    expect_res(8'h0E, 8'hFE, 1'b0, 1'b0); run_op("n100_n7", 8'h9C, 8'hF9, 0);
    expect_res(8'h80, 8'h00, 1'b0, 1'b1); run_op("n128_n1", 8'h80, 8'hFF, 0);
    expect_res(8'h80, 8'h00, 1'b0, 1'b0); run_op("n128_p1", 8'h80, 8'h01, 0);
    expect_res(8'h00, 8'h7F, 1'b0, 1'b0); run_op("p127_n128", 8'h7F, 8'h80, 0);
    expect_res(8'hFF, 8'h05, 1'b1, 1'b0); run_op("p5_zero", 8'd5, 8'd0, 0);

    // Stray start while busy is ignored.
    expect_res(8'h0E, 8'h02, 1'b0, 1'b0); run_op("ignore_start", 8'd100, 8'd7, 4);

    // Leave nonzero results and dbz=1 so reset clearing is visible.
    expect_res(8'hFF, 8'hFB, 1'b1, 1'b0); run_op("n5_zero", 8'hFB, 8'd0, 0);

    // Asynchronous reset between edges in the middle of ITER.
    @(negedge clk);
    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    check("abort.quotient", 32'(quotient), 32'd0);
    check("abort.remainder", 32'(remainder), 32'd0);
    check("abort.dbz", 32'(dbz), 32'd0);
    check("abort.ovf", 32'(ovf), 32'd0);
    seen = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    check("abort.no_done", 32'(seen), 32'd0);
    $display("op abort: reset mid-iteration, done pulses seen=%0d", seen);
    expect_res(8'h03, 8'h00, 1'b0, 1'b0); run_op("p9_p3", 8'd9, 8'd3, 0);

    // Short random run against the reference model.
    for (int i = 0; i < 8; i++) begin
      ra = W'($urandom);
      rb = (i == 3) ? 8'h00 : W'($urandom);
      scoreboard.push_back(model(ra, rb));
      run_op($sformatf("rand%0d", i), ra, rb, 0);
    end

    check("scoreboard_empty", 32'(scoreboard.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
